// File: rtl/regfile_4r2w_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_4r2w_if
//  Description : Operand-read / writeback bundle for the 4-read, 2-write
//                integer register file. The pipeline side (read-operands
//                stage and both writeback slots) uses the master modport.
//                The register file uses the slave modport.
//                Ports 1/2 serve issue slot a and ports 3/4 serve slot b.
//                Write port 2 belongs to the younger slot b.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_4r2w_if #(
    parameter int DW = 32
);
    // Read ports: addresses come from the pipeline, data goes back to it
    logic [4:0]    r1_addr;
    logic [DW-1:0] r1_data;
    logic [4:0]    r2_addr;
    logic [DW-1:0] r2_data;
    logic [4:0]    r3_addr;
    logic [DW-1:0] r3_data;
    logic [4:0]    r4_addr;
    logic [DW-1:0] r4_data;

    // Write ports: writeback slot a (port 1) and the younger slot b (port 2)
    logic          we1;
    logic [4:0]    waddr1;
    logic [DW-1:0] wdata1;
    logic          we2;
    logic [4:0]    waddr2;
    logic [DW-1:0] wdata2;

    modport master (
        output r1_addr, r2_addr, r3_addr, r4_addr,
        output we1, waddr1, wdata1, we2, waddr2, wdata2,
        input  r1_data, r2_data, r3_data, r4_data
    );

    modport slave (
        input  r1_addr, r2_addr, r3_addr, r4_addr,
        input  we1, waddr1, wdata1, we2, waddr2, wdata2,
        output r1_data, r2_data, r3_data, r4_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_4r2w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_4r2w
//  Description : Architectural integer register file for the dual-issue
//                pipeline. It has NREG registers of DW bits, four
//                combinational read ports and two write ports. Register 0
//                has no storage and always reads as zero. When both write
//                ports hit the same register on one edge, port 2 (the
//                younger slot b) wins.
//                Optional build macro REGFILE_WRITE_BYPASS_EN: each read
//                port returns same-cycle write data, with port 2 taking
//                priority over port 1. Bypass is suppressed while reset
//                is high. Without the macro, a write becomes visible on
//                the cycle after its edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_4r2w #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    regfile_4r2w_if.slave rf
);

    localparam int c_AW = 5;

    // Storage for registers 1..NREG-1 only; index 0 never exists
    logic [DW-1:0] r_regs [NREG-1:1];

    // Qualified write enables: address 0 and out-of-range addresses are dropped
    logic w_wen1;
    logic w_wen2;

    assign w_wen1 = rf.we1 && (rf.waddr1 != '0) && (int'(rf.waddr1) < NREG);
    assign w_wen2 = rf.we2 && (rf.waddr2 != '0) && (int'(rf.waddr2) < NREG);

    // Register update: async clear; port 2 is applied last so it wins a same-address conflict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wen1) begin
                r_regs[rf.waddr1] <= rf.wdata1;
            end
            if (w_wen2) begin
                r_regs[rf.waddr2] <= rf.wdata2;
            end
        end
    end

    // One read port: zero for r0 or unmapped addresses, else storage (optionally bypassed)
    function automatic logic [DW-1:0] f_read(input logic [c_AW-1:0] addr);
        logic [DW-1:0] v;
        v = '0;
        if ((addr != '0) && (int'(addr) < NREG)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
            if (reset) begin
                v = '0;
            end else if (rf.we2 && (rf.waddr2 == addr)) begin
                v = rf.wdata2;
            end else if (rf.we1 && (rf.waddr1 == addr)) begin
                v = rf.wdata1;
            end else begin
                v = r_regs[addr];
            end
`else
            v = r_regs[addr];
`endif
        end
        return v;
    endfunction

    // Four independent combinational read ports; aliasing addresses is harmless
    always_comb begin
        rf.r1_data = f_read(rf.r1_addr);
        rf.r2_data = f_read(rf.r2_addr);
        rf.r3_data = f_read(rf.r3_addr);
        rf.r4_data = f_read(rf.r4_addr);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_4r2w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_4r2w
//  Description : Self-checking bench for regfile_4r2w. A reference model
//                of the register array supplies expected read data. The
//                expected data is queued when each cycle's stimulus is
//                driven and compared when the read ports settle. The
//                same REGFILE_WRITE_BYPASS_EN macro selects the model's
//                bypass behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_4r2w;

    localparam int c_DW = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_4r2w_if #(.DW(c_DW)) u_if ();

    regfile_4r2w #(
        .NREG (32),
        .DW   (c_DW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .rf    (u_if)
    );

    logic [31:0] m_regs [32];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // Reference read: r0 is zero, optional same-cycle bypass with port 2 first
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (reset) return 32'h0;
        if (u_if.we2 && (u_if.waddr2 == a)) return u_if.wdata2;
        if (u_if.we1 && (u_if.waddr1 == a)) return u_if.wdata1;
`endif
        return m_regs[a];
    endfunction

    task automatic pop_check(input string tag);
        check($sformatf("%s.rd1", tag), u_if.r1_data, exp_q.pop_front());
        check($sformatf("%s.rd2", tag), u_if.r2_data, exp_q.pop_front());
        check($sformatf("%s.rd3", tag), u_if.r3_data, exp_q.pop_front());
        check($sformatf("%s.rd4", tag), u_if.r4_data, exp_q.pop_front());
    endtask

    // One clock cycle: drive at negedge, check reads mid-cycle, update model at posedge
    task automatic step(
        input string       tag,
        input logic        rst_v,
        input logic        w1, input logic [4:0] a1, input logic [31:0] d1,
        input logic        w2, input logic [4:0] a2, input logic [31:0] d2,
        input logic [4:0]  q1, input logic [4:0] q2, input logic [4:0] q3, input logic [4:0] q4,
        input logic        use_exp,
        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4
    );
        @(negedge clk);
        reset = rst_v;
        if (rst_v) m_clear();
        u_if.we1     = w1;
        u_if.waddr1  = a1;
        u_if.wdata1  = d1;
        u_if.we2     = w2;
        u_if.waddr2  = a2;
        u_if.wdata2  = d2;
        u_if.r1_addr = q1;
        u_if.r2_addr = q2;
        u_if.r3_addr = q3;
        u_if.r4_addr = q4;
        if (use_exp) begin
            exp_q.push_back(e1);
            exp_q.push_back(e2);
            exp_q.push_back(e3);
            exp_q.push_back(e4);
        end else begin
            exp_q.push_back(m_read(q1));
            exp_q.push_back(m_read(q2));
            exp_q.push_back(m_read(q3));
            exp_q.push_back(m_read(q4));
        end
        #2;
        pop_check(tag);
        @(posedge clk);
        if (!reset) begin
            if (w1 && (a1 != 5'd0)) m_regs[a1] = d1;
            if (w2 && (a2 != 5'd0)) m_regs[a2] = d2;
        end
    endtask

    // Read-only cycle against the model
    task automatic read4(input string tag, input logic [4:0] q1, input logic [4:0] q2,
                         input logic [4:0] q3, input logic [4:0] q4);
        step(tag, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, q1, q2, q3, q4,
             1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e_same;
        logic [31:0] e_both;
        logic        rr, w1, w2;
        logic [4:0]  a1, a2, q[4];
        logic [31:0] d1, d2;

        reset = 1'b1;
        m_clear();
        u_if.we1 = 1'b0; u_if.waddr1 = '0; u_if.wdata1 = '0;
        u_if.we2 = 1'b0; u_if.waddr2 = '0; u_if.wdata2 = '0;
        u_if.r1_addr = '0; u_if.r2_addr = '0; u_if.r3_addr = '0; u_if.r4_addr = '0;

        // Reset state; writes under reset are discarded
        step("rst_hold", 1'b1, 1'b1, 5'd6, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'hCAFE_F00D,
             5'd6, 5'd7, 5'd1, 5'd31, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        step("rst_drop", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             5'd6, 5'd7, 5'd1, 5'd31, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);

        // Write r5, then assert reset asynchronously mid-cycle
        step("wr5", 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0,
             5'd5, 5'd5, 5'd5, 5'd5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        u_if.we1 = 1'b0; u_if.we2 = 1'b0;
        u_if.r1_addr = 5'd5; u_if.r2_addr = 5'd5; u_if.r3_addr = 5'd5; u_if.r4_addr = 5'd5;
        #1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_1234);
        pop_check("pre_async");
        #1;
        reset = 1'b1;
        m_clear();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        #1;
        pop_check("async_rst");
        step("rst_edge", 1'b1, 1'b1, 5'd5, 32'h5555_5555, 1'b1, 5'd8, 32'h8888_8888,
             5'd5, 5'd8, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step("post_rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 5'(4*i), 5'(4*i+1), 5'(4*i+2), 5'(4*i+3), 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        end

        // Dual write to distinct addresses
        step("dual_wr", 1'b0, 1'b1, 5'd3, 32'hAAAA_5555, 1'b1, 5'd7, 32'h1234_5678,
             5'd1, 5'd2, 5'd10, 5'd11, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step("dual_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             5'd3, 5'd7, 5'd3, 5'd7, 1'b1, 32'hAAAA_5555, 32'h1234_5678, 32'hAAAA_5555, 32'h1234_5678);

        // Same-address conflict: port 2 wins
        step("conf_wr", 1'b0, 1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222,
             5'd3, 5'd7, 5'd12, 5'd13, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step("conf_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222);

        // Writes to r0 are ignored; the rest of the file is untouched
        step("zero_wr", 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hDEAD_BEEF,
             5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        step("zero_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            read4("zero_scan", 5'(4*i), 5'(4*i+1), 5'(4*i+2), 5'(4*i+3));
        end

        // Same-cycle read of a register being written
`ifdef REGFILE_WRITE_BYPASS_EN
        e_same = 32'h2;
        e_both = 32'h4;
`else
        e_same = 32'h1;
        e_both = 32'h2;
`endif
        step("r4_init", 1'b0, 1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 32'h0,
             5'd1, 5'd2, 5'd3, 5'd5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step("rw_same", 1'b0, 1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 32'h0,
             5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 32'h0, e_same, 32'h0, 32'h0);
        step("rw_both", 1'b0, 1'b1, 5'd4, 32'h3, 1'b1, 5'd4, 32'h4,
             5'd4, 5'd4, 5'd4, 5'd4, 1'b1, e_both, e_both, e_both, e_both);
        step("rw_after", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             5'd4, 5'd4, 5'd4, 5'd4, 1'b1, 32'h4, 32'h4, 32'h4, 32'h4);

        // Random traffic against the model, with occasional reset pulses
        for (int n = 0; n < 10000; n++) begin
            rr = ($urandom_range(0, 199) == 0);
            w1 = 1'($urandom_range(0, 1));
            w2 = 1'($urandom_range(0, 1));
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            d1 = $urandom();
            d2 = $urandom();
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0:       q[k] = a1;
                    1:       q[k] = a2;
                    default: q[k] = 5'($urandom_range(0, 31));
                endcase
            end
            step("rand", rr, w1, a1, d1, w2, a2, d2, q[0], q[1], q[2], q[3],
                 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_4r2w.md
Name: regfile_4r2w

Overview:
- Architectural integer register file for the dual-issue pipeline: 32 x 32-bit registers, 4 read ports, 2 write ports.
- The responder end of the operand-read interface. The read-operands stage drives the four read addresses and consumes the data. Read ports 1/2 serve slot a; ports 3/4 serve slot b.
- Write ports are driven by writeback slots a and b. Slot b is the younger instruction in program order.

Parameters:
- NREG, 32, number of architectural registers; address width is fixed at 5 bits.
- DW, 32, data width in bits.

Ports:
- clk  in  1  clock; all writes on rising edge
- reset  in  1  asynchronous active-high reset
- r1_addr  in  5  read port 1 address (slot a src1)
- r1_data  out  32  read port 1 data
- r2_addr  in  5  read port 2 address (slot a src2)
- r2_data  out  32  read port 2 data
- r3_addr  in  5  read port 3 address (slot b src1)
- r3_data  out  32  read port 3 data
- r4_addr  in  5  read port 4 address (slot b src2)
- r4_data  out  32  read port 4 data
- we1  in  1  write enable, writeback slot a
- waddr1  in  5  write address, slot a
- wdata1  in  32  write data, slot a
- we2  in  1  write enable, writeback slot b (younger)
- waddr2  in  5  write address, slot b
- wdata2  in  32  write data, slot b

Behaviour:
- Storage: array regs[1..31] of DW-bit flops. Register 0 has no storage.
- Reset:
  - reset high asynchronously clears regs[1..31] to 0 immediately, independent of clk.
  - All r*_data read 0 while reset is held; reads are combinational from cleared storage.
  - Writes presented during reset are discarded.
  - Reset asserted mid-operation discards any write whose edge coincides with reset high.
- Write, on rising clk edge when reset is low:
  - if we1 && waddr1!=0: regs[waddr1] <= wdata1.
  - if we2 && waddr2!=0: regs[waddr2] <= wdata2.
  - Same-address conflict (we1 && we2 && waddr1==waddr2!=0): port 2 wins, because slot b is younger; wdata1 is dropped.
  - Different addresses: both writes commit in the same cycle.
  - Write to address 0 is ignored on either port.
- Read:
  - Combinational, zero-cycle latency: rN_data = (rN_addr==0) ? 0 : regs[rN_addr].
  - All four ports are independent. Any ports may alias the same address with no conflict.
  - A read in the same cycle as a write to that address returns the old value; the new value is visible from the next cycle. This is the default, without the optional feature below.
- No handshake and no stall; the block is always ready.
- No X propagation: outputs are defined for every address value.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- When defined, each read port bypasses same-cycle writes:
  - if we2 && waddr2==rN_addr && rN_addr!=0, then rN_data = wdata2;
  - else if we1 && waddr1==rN_addr && rN_addr!=0, then rN_data = wdata1;
  - else array value.
  - Priority (port 2 over port 1) matches the write-conflict rule.
  - During reset, bypass is suppressed and reads return 0.
  - This lets the pipeline drop the wb-stage forwarding source.
- When undefined, reads return array contents only; same-cycle writes are invisible until the next cycle.

Test Plan:
- Reset: assert reset asynchronously mid-cycle after writing r5=0x1234 -> r1_data for addr 5 reads 0x00000000 before the next clk edge; after release, all 32 addresses read 0.
- Dual write, distinct addresses: we1 r3=0xAAAA5555 and we2 r7=0x12345678 on one edge -> next cycle, r1..r4 set to addr 3,7,3,7 read 0xAAAA5555, 0x12345678, 0xAAAA5555, 0x12345678.
- Conflict: we1 and we2 both to r9, wdata1=0x11111111, wdata2=0x22222222 -> r9 reads 0x22222222 on all four ports.
- Zero register: we1 r0=0xFFFFFFFF and we2 r0=0xDEADBEEF -> r0 reads 0 on all ports; r1..r31 unchanged.
- Same-cycle read/write: r4 holds 0x1, write r4=0x2 with r2_addr=4 in the same cycle -> r2_data=0x1 without the macro, 0x2 with REGFILE_WRITE_BYPASS_EN. With both ports writing r4 (0x3 on port 1, 0x4 on port 2), bypass returns 0x4.
- Random: 10k cycles of random we/addr/data against a reference model (port-2 priority, r0 zero) -> all read ports match every cycle, with and without the macro.
